// File: rtl/rst_seq.sv
// Reset sequencer: releases NSTAGE downstream resets in ascending order, waiting for
// each stage's ack plus HOLD cycles, and re-asserts them in descending order on loss.
module rst_seq #(
  parameter int unsigned NSTAGE      = 4,
  parameter int unsigned HOLD        = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              sys_ready,
  input  logic              locked,
  input  logic [NSTAGE-1:0] stage_ack,
  output logic [NSTAGE-1:0] stage_rst,
  output logic              all_up,
  output logic              fault,
  output logic [2:0]        state
);

  localparam int unsigned IdxW  = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam int unsigned HoldW = $clog2(HOLD + 1);
  localparam int unsigned ToW   = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NSTAGE - 1);
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(HOLD - 1);
  localparam logic [HoldW-1:0]  HoldMax  = HoldW'(HOLD);
  localparam logic [ToW-1:0]    ToLast   = ToW'(ACK_TIMEOUT - 1);
  localparam logic [ToW-1:0]    ToMax    = ToW'(ACK_TIMEOUT);
  localparam logic [NSTAGE-1:0] AllOnes  = '1;
  localparam logic [NSTAGE-1:0] TopBit   = AllOnes ^ (AllOnes >> 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRelease  = 3'd1,
    StUp       = 3'd2,
    StTeardown = 3'd3,
    StFault    = 3'd4
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [HoldW-1:0]  hcnt_q;
  logic [ToW-1:0]    tcnt_q;
  logic              acked_q;
  logic [NSTAGE-1:0] stage_rst_q;
  logic              all_up_q;
  logic              fault_q;

  logic go;
  logic cur_ack;

  assign go      = sys_ready & locked;
  assign cur_ack = stage_ack[idx_q];

  // Released stages are always a contiguous low-index run of zeros in stage_rst_q, so
  // releasing the next stage is a left shift and re-asserting the highest released stage
  // is a right shift with a one fed in at the top.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      hcnt_q      <= '0;
      tcnt_q      <= '0;
      acked_q     <= 1'b0;
      stage_rst_q <= AllOnes;
      all_up_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          stage_rst_q <= AllOnes;
          idx_q       <= '0;
          hcnt_q      <= '0;
          tcnt_q      <= '0;
          acked_q     <= 1'b0;
          if (go) begin
            state_q     <= StRelease;
            stage_rst_q <= AllOnes << 1;
          end
        end

        StRelease, StUp: begin
          if (!go) begin
            state_q     <= StTeardown;
            all_up_q    <= 1'b0;
            stage_rst_q <= (stage_rst_q >> 1) | TopBit;
            hcnt_q      <= '0;
          end else if (state_q == StRelease) begin
            if (acked_q) begin
              // Ack already latched: only the hold interval matters now.
              if (hcnt_q == HoldLast) begin
                acked_q <= 1'b0;
                hcnt_q  <= '0;
                tcnt_q  <= '0;
                if (idx_q == LastIdx) begin
                  state_q  <= StUp;
                  all_up_q <= 1'b1;
                end else begin
                  idx_q       <= idx_q + 1'b1;
                  stage_rst_q <= stage_rst_q << 1;
                end
              end else if (hcnt_q < HoldMax) begin
                hcnt_q <= hcnt_q + 1'b1;
              end
            end else if (cur_ack) begin
              // An ack on the timeout cycle takes precedence over the timeout.
              acked_q <= 1'b1;
              hcnt_q  <= '0;
            end else if (tcnt_q == ToLast) begin
              state_q     <= StFault;
              stage_rst_q <= AllOnes;
              fault_q     <= 1'b1;
              all_up_q    <= 1'b0;
              tcnt_q      <= ToMax;
            end else if (tcnt_q < ToMax) begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end

        StTeardown: begin
          if (hcnt_q == HoldLast) begin
            hcnt_q <= '0;
            if (stage_rst_q[0]) begin
              state_q <= StIdle;
              idx_q   <= '0;
            end else begin
              stage_rst_q <= (stage_rst_q >> 1) | TopBit;
            end
          end else if (hcnt_q < HoldMax) begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end

        StFault: begin
          stage_rst_q <= AllOnes;
          if (!sys_ready) begin
            state_q <= StIdle;
            fault_q <= 1'b0;
            idx_q   <= '0;
            tcnt_q  <= '0;
            hcnt_q  <= '0;
            acked_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= StIdle;
          stage_rst_q <= AllOnes;
          all_up_q    <= 1'b0;
          fault_q     <= 1'b0;
        end
      endcase
    end
  end

  assign stage_rst = stage_rst_q;
  assign all_up    = all_up_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule
